// File: rtl/pipe_backend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_backend_pkg
//  Purpose  : Pipe specification word encoding, bus field offsets and the
//             shared count type used by pipe stages.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_backend_pkg;

  // Pipe specification word: low byte is the data width, bit 8 enables
  // the start/stop framing fields.
  localparam int PS_d8         = 32'h0000_0008;
  localparam int PS_START_STOP = 32'h0000_0100;

  // Packed bus layout, LSB first: ready, valid, data, stop, start.
  localparam int c_ready_bit = 0;
  localparam int c_valid_bit = 1;
  localparam int c_data_lo   = 2;

  // Occupancy of a two-entry buffer (0..2).
  typedef logic [1:0] count_t;

  function automatic int p_data_w(input int spec);
    return spec & 32'h0000_00FF;
  endfunction

  function automatic bit p_has_start_stop(input int spec);
    return (spec & PS_START_STOP) != 0;
  endfunction

  function automatic int p_w(input int spec);
    return p_data_w(spec) + 2 + (p_has_start_stop(spec) ? 2 : 0);
  endfunction

  function automatic int p_stop_bit(input int spec);
    return c_data_lo + p_data_w(spec);
  endfunction

  function automatic int p_start_bit(input int spec);
    return c_data_lo + p_data_w(spec) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_backend_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_entry_2
//  Purpose  : Two-entry FIFO register pair (head/tail) with occupancy count.
//             Head is always the oldest word; emptied slots read as zero.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_entry_2
  import pipe_backend_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output count_t           o_count,
  output logic [WIDTH-1:0] o_head
);

  count_t           count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // Next-state: push/pop against the current occupancy; a full buffer never
  // sees a push because the producer's ready is low.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (i_push) begin
          head_d  = i_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (i_push && !i_pop) begin
          tail_d  = i_data;
          count_d = 2'd2;
        end else if (i_push && i_pop) begin
          head_d  = i_data;
        end else if (i_pop) begin
          head_d  = '0;
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (i_pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  // State registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign o_count = count_q;
  assign o_head  = head_q;

endmodule
`default_nettype wire

// File: rtl/pipe_backend.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_backend
//  Purpose  : Output stage of a pipe block. Buffers discrete start/stop/data
//             words in a two-entry skid buffer and drives them onto the packed
//             outgoing pipe. out_ready depends only on registers and reset.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_backend
  import pipe_backend_pkg::*;
#(
  parameter int PipeSpec = PS_d8 | PS_START_STOP
) (
  input  logic                          clock,
  input  logic                          reset,
  inout  wire  [p_w(PipeSpec)-1:0]      pipe_out,
  input  logic                          out_start,
  input  logic                          out_stop,
  input  logic [p_data_w(PipeSpec)-1:0] out_data,
  input  logic                          out_valid,
  output logic                          out_ready
);

  localparam int DATA_W  = p_data_w(PipeSpec);
  localparam bit HAS_SS  = p_has_start_stop(PipeSpec);
  localparam int ENTRY_W = DATA_W + (HAS_SS ? 2 : 0);

  count_t               w_count;
  logic [ENTRY_W-1:0]   w_head;
  logic [ENTRY_W-1:0]   w_entry_in;
  logic                 w_pipe_valid;
  logic                 w_pipe_ready;
  logic                 w_push;
  logic                 w_pop;

  // Handshakes. Valid is forced low during reset so nothing is popped or
  // presented while the buffer is being cleared.
  assign w_pipe_ready = pipe_out[c_ready_bit];
  assign w_pipe_valid = (w_count != 2'd0) && !reset;
  assign out_ready    = (w_count != 2'd2) && !reset;
  assign w_push       = out_valid && out_ready;
  assign w_pop        = w_pipe_valid && w_pipe_ready;

  // Stored word is {start, stop, data} when framing exists, else just data.
  generate
    if (HAS_SS) begin : g_ss
      assign w_entry_in = {out_start, out_stop, out_data};
      assign pipe_out[p_stop_bit(PipeSpec)]  = w_head[DATA_W];
      assign pipe_out[p_start_bit(PipeSpec)] = w_head[DATA_W+1];
    end else begin : g_no_ss
      logic w_unused_ss;
      assign w_entry_in  = out_data;
      assign w_unused_ss = out_start ^ out_stop;
    end
  endgenerate

  assign pipe_out[c_valid_bit]          = w_pipe_valid;
  assign pipe_out[c_data_lo +: DATA_W]  = w_head[DATA_W-1:0];

  pipe_skid_entry_2 #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry_in),
    .o_count (w_count),
    .o_head  (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_backend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_backend
//  Purpose  : Self-checking bench for pipe_backend (8-bit data, start/stop).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_backend;

  localparam int PS = 32'h0000_0108;
  localparam int PW = 12;

  logic        clock;
  logic        reset;
  logic        ds_ready;
  logic        out_start;
  logic        out_stop;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  wire [PW-1:0] pipe_bus;

  int n_vec = 0;
  int n_err = 0;

  assign pipe_bus[0] = ds_ready;

  pipe_backend #(.PipeSpec(PS)) dut (
    .clock     (clock),
    .reset     (reset),
    .pipe_out  (pipe_bus),
    .out_start (out_start),
    .out_stop  (out_stop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         rdy;
    bit         v;
    logic [7:0] d;
    bit         e_or;
    bit         e_v;
    logic [7:0] e_d;
  } vec_t;

  vec_t tbl [14];

  // Inputs change on the falling edge; outputs are checked 1 ns later.
  task automatic drive(input bit r, input bit rdy, input bit v, input bit s,
                       input bit p, input logic [7:0] d);
    @(negedge clock);
    reset     = r;
    ds_ready  = rdy;
    out_valid = v;
    out_start = s;
    out_stop  = p;
    out_data  = d;
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  logic [9:0] mq[$];

  initial begin
    reset = 1'b1; ds_ready = 1'b0; out_valid = 1'b0;
    out_start = 1'b0; out_stop = 1'b0; out_data = 8'h00;

    // Reset, pass-through and stall-fill, one row per cycle.
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00};
    tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00};
    tbl[2]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00};
    tbl[3]  = '{0, 1, 1, 8'h55, 1, 0, 8'h00};
    tbl[4]  = '{0, 1, 0, 8'h00, 1, 1, 8'h55};
    tbl[5]  = '{0, 1, 0, 8'h00, 1, 0, 8'h00};
    tbl[6]  = '{0, 0, 1, 8'h11, 1, 0, 8'h00};
    tbl[7]  = '{0, 0, 1, 8'h22, 1, 1, 8'h11};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 1, 8'h11};
    tbl[9]  = '{0, 0, 0, 8'h00, 0, 1, 8'h11};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 1, 8'h11};
    tbl[11] = '{0, 1, 0, 8'h00, 0, 1, 8'h11};
    tbl[12] = '{0, 1, 0, 8'h00, 1, 1, 8'h22};
    tbl[13] = '{0, 1, 0, 8'h00, 1, 0, 8'h00};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].v, 1'b0, 1'b0, tbl[i].d);
      chk($sformatf("tbl%0d out_ready", i), int'(out_ready), int'(tbl[i].e_or));
      chk($sformatf("tbl%0d valid", i), int'(pipe_bus[1]), int'(tbl[i].e_v));
      if (!tbl[i].rst)
        chk($sformatf("tbl%0d data", i), int'(pipe_bus[9:2]), int'(tbl[i].e_d));
    end

    // Ready indecision: ready pulses high then drops before the edge.
    drive(0, 0, 1, 0, 0, 8'h45);
    @(negedge clock);
    out_valid = 1'b0; ds_ready = 1'b1;
    #2 ds_ready = 1'b0;
    #1;
    chk("indec valid pre", int'(pipe_bus[1]), 1);
    drive(0, 0, 0, 0, 0, 8'h00);
    chk("indec valid held", int'(pipe_bus[1]), 1);
    chk("indec data held", int'(pipe_bus[9:2]), 'h45);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("indec data pop", int'(pipe_bus[9:2]), 'h45);
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("indec valid gone", int'(pipe_bus[1]), 0);

    // Streaming 0x01..0x08 with framing on first and last word.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) drive(0, 1, 1, i == 1, i == 8, 8'(i));
      else        drive(0, 1, 0, 0, 0, 8'h00);
      chk($sformatf("stream%0d out_ready", i), int'(out_ready), 1);
      if (i > 1) begin
        chk($sformatf("stream%0d valid", i), int'(pipe_bus[1]), 1);
        chk($sformatf("stream%0d data", i), int'(pipe_bus[9:2]), i - 1);
        chk($sformatf("stream%0d start", i), int'(pipe_bus[11]), int'(i == 2));
        chk($sformatf("stream%0d stop", i), int'(pipe_bus[10]), int'(i == 9));
      end
    end
    drive(0, 1, 0, 0, 0, 8'h00);
    chk("stream drained", int'(pipe_bus[1]), 0);

    // Reset while full: both words discarded.
    drive(0, 0, 1, 0, 0, 8'hA0);
    drive(0, 0, 1, 0, 0, 8'hA1);
    drive(0, 0, 0, 0, 0, 8'h00);
    chk("full out_ready", int'(out_ready), 0);
    chk("full head", int'(pipe_bus[9:2]), 'hA0);
    drive(1, 0, 0, 0, 0, 8'h00);
    chk("rst valid", int'(pipe_bus[1]), 0);
    chk("rst out_ready", int'(out_ready), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 8'h00);
      chk($sformatf("post-rst%0d valid", i), int'(pipe_bus[1]), 0);
      chk($sformatf("post-rst%0d data", i), int'(pipe_bus[9:2]), 0);
      chk($sformatf("post-rst%0d out_ready", i), int'(out_ready), 1);
    end

    // Random traffic against a FIFO-of-words reference model.
    mq.delete();
    for (int c = 0; c < 2000; c++) begin
      bit         r, rdy, v, s, p, e_or, e_v;
      logic [7:0] d;
      r   = ($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom);
      p   = 1'($urandom);
      d   = 8'($urandom);
      drive(r, rdy, v, s, p, d);
      e_or = !r && (mq.size() < 2);
      e_v  = !r && (mq.size() > 0);
      chk($sformatf("rnd%0d out_ready", c), int'(out_ready), int'(e_or));
      chk($sformatf("rnd%0d valid", c), int'(pipe_bus[1]), int'(e_v));
      if (e_v)
        chk($sformatf("rnd%0d word", c), int'({pipe_bus[11], pipe_bus[10], pipe_bus[9:2]}), int'(mq[0]));
      else if (!r)
        chk($sformatf("rnd%0d idle word", c), int'(pipe_bus[11:2]), 0);
      if (r) begin
        mq.delete();
      end else begin
        if (e_v && rdy) void'(mq.pop_front());
        if (v && e_or) mq.push_back({s, p, d});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_backend.md
Name: pipe_backend

Overview:
- Output stage of a pipe-based block; the mirror of pipe_frontend.
- Internal logic presents start/stop/data/valid on discrete signals and sees a discrete ready. The block packs them onto the outgoing pipe bus.
- It holds a 2-entry skid buffer, so `out_ready` has no combinational dependence on the downstream pipe ready bit. Full throughput is kept.
- Sits directly downstream of the block logic and feeds the next stage's pipe_frontend.

Parameters:
- PipeSpec, default `PS_d8 | PS_START_STOP`: pipe specification word. It sets the data width (`P_Data_w`) and which optional fields (start/stop) exist on the bus.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pipe_out  inout  `P_w(PipeSpec)`
  - Packed outgoing pipe.
  - The block drives start, stop, data and valid.
  - The ready bit is driven by the downstream stage.
- out_start  input  1  start flag of the offered word; ignored if PipeSpec lacks `PS_START_STOP`.
- out_stop  input  1  stop flag of the offered word; ignored if PipeSpec lacks `PS_START_STOP`.
- out_data  input  `P_Data_w(PipeSpec)`  offered data word.
- out_valid  input  1  offered word is valid.
- out_ready  output  1  the block accepts the offered word this cycle.

Behaviour:
- Storage: two entries, head (H) and tail (T), each holding {start, stop, data}. A 2-bit count holds 0..2.
- Derived signals:
  - push = out_valid & out_ready.
  - pop = pipe valid & pipe ready.
  - Pipe ready is the ready bit unpacked from `pipe_out`.
- Outputs, all decoded from registers only:
  - out_ready = (count != 2) & !reset.
  - pipe valid = (count != 0).
  - pipe start/stop/data = H fields.
  - When count == 0, H fields are 0.
- Reset: count = 0 and H, T are cleared to 0. While reset is high, out_ready = 0 and pipe valid = 0. out_ready rises in the first cycle after reset deasserts.
- Updates per rising edge:
  - count 0, push: H <= in; count 1.
  - count 1, push & !pop: T <= in; count 2.
  - count 1, push & pop: H <= in; count stays 1.
  - count 1, !push & pop: H <= 0; count 0.
  - count 2, pop: H <= T; T <= 0; count 1. Push cannot occur because out_ready = 0.
  - No push and no pop: state holds.
- Latency: a word pushed in cycle N appears on `pipe_out` with valid in cycle N+1 at the earliest.
- Throughput: one word per cycle while downstream ready is held high.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Pipe protocol: once pipe valid is asserted, valid and the fields hold stable until popped, regardless of ready toggling.
- Reset mid-operation: buffered words are discarded without error. Valid drops in the reset cycle.
- Fields absent from PipeSpec are neither stored nor driven.

Decomposition:
- Shared package (`pipe_defs.v` macros, already present): `P_w`, `P_Data_w`, `PS_START_STOP` and the pack/unpack field offsets. No new constants are needed.
- Packing uses the existing p_pack_start_stop, p_pack_data and p_pack_valid_ready helpers.
- A natural sub-module is pipe_skid_entry_2, the 2-entry register pair plus count. It is parameterised on the stored width, so pipe_frontend can reuse it later.

Test Plan:
1. Reset:
   - After reset, pipe valid = 0.
   - One cycle later out_ready = 1.
2. Pass-through: downstream ready = 1; push {0,0,0x55}.
   - Next cycle pipe shows {0,0,0x55}, valid = 1.
   - The cycle after, valid = 0.
3. Stall fill: downstream ready = 0; push 0x11, then 0x22.
   - out_ready falls after the second push.
   - Pipe holds 0x11 stable for 3 cycles.
   - Set ready = 1: pipe shows 0x11, then 0x22.
   - out_ready returns 1 one cycle after the first pop.
4. Ready indecision: with 0x45 buffered, toggle downstream ready mid-cycle 1→0 before the edge.
   - 0x45 and valid stay stable until an edge with ready = 1.
   - Then valid = 0.
5. Streaming: downstream ready = 1; push 0x01..0x08 back to back with start on 0x01 and stop on 0x08.
   - 8 consecutive valid cycles in order.
   - Start and stop are delivered with the correct words.
   - out_ready is never deasserted.
6. Reset mid-operation: count = 2 (0xA0, 0xA1); assert reset for one cycle.
   - pipe valid = 0 in the reset cycle and stays 0 with no pushes.
   - Neither word reappears.
